heartaware_ui_ctrl: RTL and testbench



---
 rtl/heartaware_ui_pkg.sv | 23 ++
 rtl/debounce_pulse.sv | 45 ++++
 rtl/heartaware_ui_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_heartaware_ui_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heartaware_ui_pkg.sv
// Shared encodings and 25 MHz timing defaults for the HeartAware UI controller.
// Latency: none (constants only).
// Backpressure: not applicable.
package heartaware_ui_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MENU    = 2'd1,
        MEASURE = 2'd2,
        DISPLAY = 2'd3
    } ui_state_t;

    localparam int BTN_NEXT   = 0;
    localparam int BTN_SELECT = 1;
    localparam int BTN_BACK   = 2;
    localparam int N_BTN      = 3;

    localparam int CLK_HZ              = 25_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int DEF_TICK_DIV        = CLK_HZ;
    localparam int DEF_TIMEOUT_S       = 30;

endpackage

// File: rtl/debounce_pulse.sv
// Two-flop synchronizer plus counter debounce for one asynchronous input, with rise pulse.
// Latency: clean and rise update 2 + DEBOUNCE_CYCLES cycles after a stable raw change.
// Backpressure: none, samples every cycle.
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            rise <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the stability window.
            if (sync == clean) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                clean <= sync;
                rise  <= sync;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/heartaware_ui_ctrl.sv
// HeartAware UI: debounced inputs, 1 Hz tick, mode/measurement FSM with idle timeout (HEARTAWARE_UI_AUTOREPEAT_EN adds next auto-repeat).
// Latency: raw button edge to state change 2 + DEBOUNCE_CYCLES + 1 cycles; measure_start/abort registered with the transition.
// Backpressure: none, all inputs are sampled every cycle and outputs are pulses or levels.
module heartaware_ui_ctrl
    import heartaware_ui_pkg::*;
#(
    parameter int N_SW            = 16,
    parameter int N_MODES         = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int TIMEOUT_S       = DEF_TIMEOUT_S
) (
    input  logic                       clock_25mhz,
    input  logic                       system_reset,
    input  logic [N_SW-1:0]            sw_raw,
    input  logic                       btn_next_raw,
    input  logic                       btn_select_raw,
    input  logic                       btn_back_raw,
    input  logic                       measure_done,
    output logic [N_SW-1:0]            sw_clean,
    output logic [1:0]                 ui_state,
    output logic [$clog2(N_MODES)-1:0] mode_sel,
    output logic                       measure_start,
    output logic                       measure_abort,
    output logic                       tick_1hz
);

    localparam int MW = $clog2(N_MODES);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(TIMEOUT_S + 1);

    logic [N_SW-1:0]  sw_rise_unused;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;

    assign btn_raw[BTN_NEXT]   = btn_next_raw;
    assign btn_raw[BTN_SELECT] = btn_select_raw;
    assign btn_raw[BTN_BACK]   = btn_back_raw;

    for (genvar gs = 0; gs < N_SW; gs++) begin : g_sw
        debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clock_25mhz),
            .rst   (system_reset),
            .raw   (sw_raw[gs]),
            .clean (sw_clean[gs]),
            .rise  (sw_rise_unused[gs])
        );
    end

    for (genvar gb = 0; gb < N_BTN; gb++) begin : g_btn
        debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clock_25mhz),
            .rst   (system_reset),
            .raw   (btn_raw[gb]),
            .clean (btn_level[gb]),
            .rise  (btn_rise[gb])
        );
    end

    logic unused_btn_level;
    assign unused_btn_level = &{1'b0, btn_level};

    logic [PW-1:0] pre_cnt;

    always_ff @(posedge clock_25mhz) begin
        if (system_reset) begin
            pre_cnt  <= '0;
            tick_1hz <= 1'b0;
        end else if (pre_cnt == PW'(TICK_DIV - 1)) begin
            pre_cnt  <= '0;
            tick_1hz <= 1'b1;
        end else begin
            pre_cnt  <= pre_cnt + PW'(1);
            tick_1hz <= 1'b0;
        end
    end

    logic next_pulse;

`ifdef HEARTAWARE_UI_AUTOREPEAT_EN
    localparam int REP_FIRST = TICK_DIV / 2;
    localparam int REP_NEXT  = (TICK_DIV / 8 > 0) ? TICK_DIV / 8 : 1;

    logic [PW-1:0] rep_cnt;
    logic          rep_phase;
    logic          rep_fire;

    // rep_cnt counts cycles since the last next pulse while the button stays held.
    assign rep_fire = btn_level[BTN_NEXT] && !btn_rise[BTN_NEXT] &&
                      (rep_cnt == (rep_phase ? PW'(REP_NEXT) : PW'(REP_FIRST)));

    always_ff @(posedge clock_25mhz) begin
        if (system_reset || !btn_level[BTN_NEXT]) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (btn_rise[BTN_NEXT] || rep_fire) begin
            rep_cnt   <= PW'(1);
            rep_phase <= rep_fire;
        end else begin
            rep_cnt <= rep_cnt + PW'(1);
        end
    end

    assign next_pulse = btn_rise[BTN_NEXT] | rep_fire;
`else
    assign next_pulse = btn_rise[BTN_NEXT];
`endif

    ui_state_t     st, st_nxt;
    logic [MW-1:0] mode_nxt;
    logic [SW-1:0] secs, secs_nxt;
    logic          start_nxt, abort_nxt;
    logic          p_back, p_select, p_next, any_press, timeout;

    assign p_back    = btn_rise[BTN_BACK];
    assign p_select  = btn_rise[BTN_SELECT] && !p_back;
    assign p_next    = next_pulse && !btn_rise[BTN_SELECT] && !p_back;
    assign any_press = btn_rise[BTN_BACK] | btn_rise[BTN_SELECT] | next_pulse;
    assign timeout   = tick_1hz && (secs == SW'(TIMEOUT_S - 1)) && !any_press;

    always_comb begin
        st_nxt    = st;
        mode_nxt  = mode_sel;
        start_nxt = 1'b0;
        abort_nxt = 1'b0;
        case (st)
            IDLE: begin
                if (p_select) st_nxt = MENU;
            end
            MENU: begin
                if (p_back) begin
                    st_nxt = IDLE;
                end else if (p_select) begin
                    st_nxt    = MEASURE;
                    start_nxt = 1'b1;
                end else if (p_next) begin
                    mode_nxt = (mode_sel == MW'(N_MODES - 1)) ? '0 : mode_sel + MW'(1);
                end else if (timeout) begin
                    st_nxt = IDLE;
                end
            end
            MEASURE: begin
                if (p_back) begin
                    st_nxt    = MENU;
                    abort_nxt = 1'b1;
                end else if (measure_done) begin
                    st_nxt = DISPLAY;
                end
            end
            DISPLAY: begin
                if (p_back || p_select) st_nxt = MENU;
                else if (timeout)       st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase

        // Seconds restart on every state entry, so IDLE and MEASURE always hold zero.
        if (st_nxt != st || any_press)
            secs_nxt = '0;
        else if (tick_1hz && (st == MENU || st == DISPLAY))
            secs_nxt = secs + SW'(1);
        else
            secs_nxt = secs;
    end

    always_ff @(posedge clock_25mhz) begin
        if (system_reset) begin
            st            <= IDLE;
            mode_sel      <= '0;
            secs          <= '0;
            measure_start <= 1'b0;
            measure_abort <= 1'b0;
        end else begin
            st            <= st_nxt;
            mode_sel      <= mode_nxt;
            secs          <= secs_nxt;
            measure_start <= start_nxt;
            measure_abort <= abort_nxt;
        end
    end

    assign ui_state = st;

endmodule

// File: tb/tb_heartaware_ui_ctrl.sv
// Directed plus randomized bench for heartaware_ui_ctrl against a cycle-level behavioural model.
module tb_heartaware_ui_ctrl;

    localparam int NSW = 4;
    localparam int NM  = 3;
    localparam int DB  = 4;
    localparam int TD  = 10;
    localparam int TO  = 3;
    localparam int MWB = $clog2(NM);
    localparam int NIN = NSW + 3;

    logic clk = 1'b0;
    logic rst;
    logic [NSW-1:0] sw_raw;
    logic bn, bs, bb, mdone;
    logic [NSW-1:0] sw_clean;
    logic [1:0]     ui_state;
    logic [MWB-1:0] mode_sel;
    logic mstart, mabort, tick;

    int n_assert  = 0;
    int n_fail    = 0;
    int tick_seen = 0;

    heartaware_ui_ctrl #(
        .N_SW(NSW), .N_MODES(NM), .DEBOUNCE_CYCLES(DB), .TICK_DIV(TD), .TIMEOUT_S(TO)
    ) dut (
        .clock_25mhz    (clk),
        .system_reset   (rst),
        .sw_raw         (sw_raw),
        .btn_next_raw   (bn),
        .btn_select_raw (bs),
        .btn_back_raw   (bb),
        .measure_done   (mdone),
        .sw_clean       (sw_clean),
        .ui_state       (ui_state),
        .mode_sel       (mode_sel),
        .measure_start  (mstart),
        .measure_abort  (mabort),
        .tick_1hz       (tick)
    );

    always #5 clk = ~clk;

    // Reference model state: inputs as {back, select, next, switches}.
    int m_state, m_mode, m_secs, cyc;
    logic m_start, m_abort, m_tick;
    logic [NIN-1:0] q1, q2, m_clean, m_rise;
    int run [NIN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [NIN-1:0] raw_now, rnew;
        logic pb, ps, pn, anyp;
        int nxt;
        raw_now = {bb, bs, bn, sw_raw};
        if (rst) begin
            m_state = 0; m_mode = 0; m_secs = 0; cyc = 0;
            m_start = 0; m_abort = 0; m_tick = 0;
            q1 = '0; q2 = '0; m_clean = '0; m_rise = '0;
            for (int i = 0; i < NIN; i++) run[i] = 0;
        end else begin
            pb   = m_rise[NSW+2];
            ps   = m_rise[NSW+1] && !pb;
            pn   = m_rise[NSW] && !m_rise[NSW+1] && !pb;
            anyp = |m_rise[NSW+2:NSW];
            nxt = m_state; m_start = 0; m_abort = 0;
            case (m_state)
                0: if (ps) nxt = 1;
                1: if (pb) nxt = 0;
                   else if (ps) begin nxt = 2; m_start = 1; end
                   else if (pn) m_mode = (m_mode + 1) % NM;
                2: if (pb) begin nxt = 1; m_abort = 1; end
                   else if (mdone) nxt = 3;
                default: if (pb || ps) nxt = 1;
            endcase
            if (nxt != m_state || anyp) m_secs = 0;
            else if (m_tick && (m_state == 1 || m_state == 3)) begin
                m_secs++;
                if (m_secs == TO) begin nxt = 0; m_secs = 0; end
            end
            m_state = nxt;
            rnew = '0;
            for (int i = 0; i < NIN; i++) begin
                if (q2[i] != m_clean[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin
                        m_clean[i] = q2[i]; rnew[i] = q2[i]; run[i] = 0;
                    end
                end else run[i] = 0;
            end
            m_rise = rnew; q2 = q1; q1 = raw_now;
            cyc++;
            m_tick = (cyc % TD == 0);
        end
    endtask

    task automatic cmp_model();
        check("model.state", 32'(ui_state), 32'(m_state));
        check("model.mode",  32'(mode_sel), 32'(m_mode));
        check("model.start", 32'(mstart),   32'(m_start));
        check("model.abort", 32'(mabort),   32'(m_abort));
        check("model.tick",  32'(tick),     32'(m_tick));
        check("model.sw",    32'(sw_clean), 32'(m_clean[NSW-1:0]));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_update();
            #1;
            if (tick === 1'b1) tick_seen++;
            cmp_model();
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: bn = v;
            1: bs = v;
            default: bb = v;
        endcase
    endtask

    // Holds a button until the cycle after the FSM has acted on its pulse.
    task automatic press_hold(input int b);
        set_btn(b, 1'b1);
        step(DB + 3);
    endtask

    task automatic release_btn(input int b);
        set_btn(b, 1'b0);
        step(DB + 3);
    endtask

    task automatic enter_display();
        press_hold(1);
        check("disp_measure", 32'(ui_state), 32'd2);
        release_btn(1);
        mdone = 1'b1;
        step(1);
        mdone = 1'b0;
        check("disp_enter", 32'(ui_state), 32'd3);
    endtask

    task automatic wait_ticks(input int base, input int target, input string tag);
        int g;
        g = 0;
        while (tick_seen - base < target && g < 200) begin
            check(tag, 32'(ui_state), 32'd3);
            step(1);
            g++;
        end
        check({tag, "_bound"}, 32'(g < 200), 32'd1);
    endtask

    initial begin
        int base, idx;
        rst = 1'b1; sw_raw = '0; bn = 1'b0; bs = 1'b0; bb = 1'b0; mdone = 1'b0;
        step(3);
        check("rst_state", 32'(ui_state), 32'd0);
        check("rst_mode",  32'(mode_sel), 32'd0);
        check("rst_start", 32'(mstart),   32'd0);
        check("rst_abort", 32'(mabort),   32'd0);
        check("rst_tick",  32'(tick),     32'd0);
        check("rst_sw",    32'(sw_clean), 32'd0);
        rst = 1'b0;

        sw_raw = 4'b1010;
        step(5);
        check("sw_early", 32'(sw_clean), 32'd0);
        step(1);
        check("sw_clean", 32'(sw_clean), 32'd10);

        for (int k = 0; k < 12; k++) begin
            bs = (k % 4 < 2);
            step(1);
            check("bounce_idle", 32'(ui_state), 32'd0);
        end
        bs = 1'b1;
        step(6);
        check("bounce_before", 32'(ui_state), 32'd0);
        step(1);
        check("bounce_menu", 32'(ui_state), 32'd1);
        release_btn(1);
        check("bounce_single", 32'(ui_state), 32'd1);

        for (int k = 0; k < 3; k++) begin
            press_hold(0);
            check("wrap_mode", 32'(mode_sel), 32'((k + 1) % NM));
            check("wrap_state", 32'(ui_state), 32'd1);
            release_btn(0);
        end

        press_hold(1);
        check("meas_state", 32'(ui_state), 32'd2);
        check("meas_start", 32'(mstart), 32'd1);
        step(1);
        check("meas_start_end", 32'(mstart), 32'd0);
        release_btn(1);
        mdone = 1'b1;
        step(1);
        mdone = 1'b0;
        check("meas_display", 32'(ui_state), 32'd3);

        press_hold(1);
        check("disp_to_menu", 32'(ui_state), 32'd1);
        release_btn(1);
        press_hold(1);
        check("abort_measure", 32'(ui_state), 32'd2);
        release_btn(1);
        bb = 1'b1;
        step(DB + 2);
        mdone = 1'b1;
        check("abort_pre", 32'(ui_state), 32'd2);
        step(1);
        mdone = 1'b0;
        check("abort_state", 32'(ui_state), 32'd1);
        check("abort_pulse", 32'(mabort), 32'd1);
        step(1);
        check("abort_end", 32'(mabort), 32'd0);
        check("abort_menu", 32'(ui_state), 32'd1);
        release_btn(2);

        enter_display();
        base = tick_seen - ((tick === 1'b1) ? 1 : 0);
        wait_ticks(base, TO, "to_wait");
        check("to_last_tick", 32'(ui_state), 32'd3);
        step(1);
        check("to_idle", 32'(ui_state), 32'd0);
        check("to_mode_kept0", 32'(mode_sel), 32'd0);

        press_hold(1);
        release_btn(1);
        press_hold(0);
        check("to_mode_set", 32'(mode_sel), 32'd1);
        release_btn(0);
        enter_display();
        base = tick_seen - ((tick === 1'b1) ? 1 : 0);
        wait_ticks(base, 2, "to2_wait");
        press_hold(0);
        check("to2_press", 32'(ui_state), 32'd3);
        release_btn(0);
        wait_ticks(base, 5, "to2_hold");
        check("to2_last_tick", 32'(ui_state), 32'd3);
        step(1);
        check("to2_idle", 32'(ui_state), 32'd0);
        check("to2_mode_kept", 32'(mode_sel), 32'd1);

        press_hold(1);
        release_btn(1);
        press_hold(0);
        release_btn(0);
        press_hold(1);
        check("rm_measure", 32'(ui_state), 32'd2);
        check("rm_mode", 32'(mode_sel), 32'd2);
        release_btn(1);
        rst = 1'b1;
        step(1);
        check("rm_state", 32'(ui_state), 32'd0);
        check("rm_mode0", 32'(mode_sel), 32'd0);
        check("rm_abort", 32'(mabort), 32'd0);
        check("rm_start", 32'(mstart), 32'd0);
        check("rm_tick", 32'(tick), 32'd0);
        check("rm_sw", 32'(sw_clean), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("rm_no_abort", 32'(mabort), 32'd0);
        end

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, NSW - 1));
                sw_raw[idx] = ~sw_raw[idx];
            end
            if ($urandom_range(0, 9) == 0) bn = ~bn;
            if ($urandom_range(0, 9) == 0) bs = ~bs;
            if ($urandom_range(0, 29) == 0) bb = ~bb;
            mdone = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 599) == 0);
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
